adv_timer_cmd_seq: RTL
======================

ADV_TIMER_CMD_SEQ -- requirements
Module: adv_timer_cmd_seq

Interface
REQ-001 Parameter SEL_W, default 8: width of the input-select configuration field.
REQ-002 clk_i  input  1  block clock; all state updates on its rising edge.
REQ-003 rstn_i  input  1  asynchronous active-low reset.
REQ-004 cmd_start_i  input  1  single-cycle start request.
REQ-005 cmd_stop_i  input  1  single-cycle stop request.
REQ-006 cmd_update_i  input  1  single-cycle request to apply new configuration.
REQ-007 cmd_reset_i  input  1  single-cycle counter reset request.
REQ-008 cmd_arm_i  input  1  single-cycle arm request for the input stage.
REQ-009 cfg_sel_i  input  SEL_W  requested input select; sampled with cmd_update_i.
REQ-010 cfg_mode_i  input  3  requested event mode; sampled with cmd_update_i.
REQ-011 cfg_oneshot_i  input  1  level: stop automatically at the next cnt_end_i.
REQ-012 cnt_end_i  input  1  counter end-of-period pulse.
REQ-013 ctrl_active_o  output  1  level: timer running.
REQ-014 ctrl_update_o  output  1  single-cycle update strobe to the input stage and counter.
REQ-015 ctrl_arm_o  output  1  single-cycle arm strobe.
REQ-016 ctrl_rst_o  output  1  single-cycle counter reset strobe.
REQ-017 cfg_sel_o  output  SEL_W  configuration presented with ctrl_update_o.
REQ-018 cfg_mode_o  output  3  configuration presented with ctrl_update_o.
REQ-019 upd_pending_o  output  1  shadow configuration captured but not yet applied.

Function
REQ-020 All outputs SHALL be registered; every command SHALL take effect on its outputs exactly one clock after the sampling edge.
REQ-021 States SHALL be IDLE, UPD_RUN and RUN; ctrl_active_o SHALL be 1 in RUN only.
REQ-022 Priority among commands sampled on the same edge SHALL be reset > stop > start; update and arm SHALL be processed in parallel with these.
REQ-023 cmd_update_i SHALL always capture cfg_sel_i/cfg_mode_i into a shadow register and set upd_pending_o; a later update before application overwrites the shadow.
REQ-024 In IDLE with pending update, the block SHALL pulse ctrl_update_o for one cycle, copy shadow to cfg_sel_o/cfg_mode_o in the same cycle, and clear upd_pending_o.
REQ-025 In RUN, a pending update SHALL be applied only in the cycle after cnt_end_i, i.e. at a period boundary.
REQ-026 cmd_start_i in IDLE SHALL move to UPD_RUN if an update is pending (or captured this cycle), else directly to RUN; cmd_start_i in RUN or UPD_RUN SHALL be ignored.
REQ-027 UPD_RUN SHALL last exactly one cycle, pulsing ctrl_update_o with ctrl_active_o=0, then enter RUN.
REQ-028 cmd_stop_i SHALL move any state to IDLE; pending update SHALL be retained.
REQ-029 cmd_reset_i SHALL pulse ctrl_rst_o for one cycle, move to IDLE, and clear upd_pending_o without changing cfg_sel_o/cfg_mode_o.
REQ-030 In RUN with cfg_oneshot_i=1, cnt_end_i SHALL move to IDLE; a pending update SHALL still be applied (ctrl_update_o pulses in the same cycle active drops).
REQ-031 cmd_arm_i SHALL pulse ctrl_arm_o one cycle later in any state except when cmd_reset_i is sampled on the same edge.
REQ-032 cnt_end_i outside RUN SHALL have no effect.
REQ-033 ctrl_update_o SHALL never be high on two consecutive cycles without a new cmd_update_i.

Reset
REQ-034 On rstn_i low: state IDLE; ctrl_active_o, ctrl_update_o, ctrl_arm_o, ctrl_rst_o, upd_pending_o = 0; cfg_sel_o, cfg_mode_o and shadow = 0; effective immediately, asynchronous to clk_i.
REQ-035 Reset asserted mid-RUN SHALL drop ctrl_active_o without a ctrl_rst_o or ctrl_update_o pulse.

Verification
REQ-036 IDLE, update sel=5 mode=3 at cycle 0 -> cycle 1: ctrl_update_o=1, cfg_sel_o=5, cfg_mode_o=3, upd_pending_o=0.
REQ-037 IDLE, update sel=2 + start same cycle -> cycle 1 ctrl_update_o=1, ctrl_active_o=0; cycle 2 onward ctrl_active_o=1.
REQ-038 RUN, update sel=7 at cycle 0, cnt_end_i at cycle 4 -> upd_pending_o=1 cycles 1-4; ctrl_update_o=1 and cfg_sel_o=7 at cycle 5 only.
REQ-039 RUN, cfg_oneshot_i=1, cnt_end_i -> next cycle ctrl_active_o=0, state IDLE; further cnt_end_i ignored.
REQ-040 RUN, reset+stop+arm same cycle -> next cycle ctrl_rst_o=1, ctrl_arm_o=0, ctrl_active_o=0, upd_pending_o=0.
REQ-041 rstn_i low mid-RUN with update pending -> all outputs 0 immediately; after release, idle with no strobes.

Source files
------------

// File: rtl/adv_timer_cmd_seq.sv
// Command sequencer for an advanced timer channel.
// Turns single-cycle start/stop/update/reset/arm commands into run state and
// strobes. New configuration is held in a shadow register. It is applied at
// once while idle, and only at a period boundary while running.
module adv_timer_cmd_seq #(
  parameter int SEL_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             cmd_start_i,
  input  logic             cmd_stop_i,
  input  logic             cmd_update_i,
  input  logic             cmd_reset_i,
  input  logic             cmd_arm_i,
  input  logic [SEL_W-1:0] cfg_sel_i,
  input  logic [2:0]       cfg_mode_i,
  input  logic             cfg_oneshot_i,
  input  logic             cnt_end_i,
  output logic             ctrl_active_o,
  output logic             ctrl_update_o,
  output logic             ctrl_arm_o,
  output logic             ctrl_rst_o,
  output logic [SEL_W-1:0] cfg_sel_o,
  output logic [2:0]       cfg_mode_o,
  output logic             upd_pending_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_UPD_RUN = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               active_q, active_d;
  logic               update_q, update_d;
  logic               arm_q, arm_d;
  logic               rst_q, rst_d;
  logic               pend_q, pend_d;
  logic [SEL_W-1:0]   sh_sel_q, sh_sel_d;
  logic [2:0]         sh_mode_q, sh_mode_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [2:0]         mode_q, mode_d;
  logic               eff_pend_s;
  logic               apply_s;

  // Next-state, shadow capture and strobe generation; reset > stop > start.
  always_comb begin
    state_d    = state_q;
    apply_s    = 1'b0;
    rst_d      = 1'b0;
    // An update sampled on this edge counts as already pending.
    eff_pend_s = pend_q | cmd_update_i;
    sh_sel_d   = cmd_update_i ? cfg_sel_i  : sh_sel_q;
    sh_mode_d  = cmd_update_i ? cfg_mode_i : sh_mode_q;
    pend_d     = eff_pend_s;
    arm_d      = cmd_arm_i & ~cmd_reset_i;

    if (cmd_reset_i) begin
      state_d = ST_IDLE;
      pend_d  = 1'b0;
      rst_d   = 1'b1;
    end else if (cmd_stop_i) begin
      // Stopping keeps any pending configuration for later application.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cmd_start_i) begin
            if (eff_pend_s) begin
              state_d = ST_UPD_RUN;
              apply_s = 1'b1;
            end else begin
              state_d = ST_RUN;
            end
          end else if (eff_pend_s) begin
            apply_s = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_UPD_RUN: begin
          state_d = ST_RUN;
        end
        ST_RUN: begin
          if (cnt_end_i) begin
            apply_s = eff_pend_s;
            if (cfg_oneshot_i) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RUN;
            end
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    if (apply_s) begin
      update_d = 1'b1;
      sel_d    = sh_sel_d;
      mode_d   = sh_mode_d;
      pend_d   = 1'b0;
    end else begin
      update_d = 1'b0;
      sel_d    = sel_q;
      mode_d   = mode_q;
    end

    active_d = (state_d == ST_RUN);
  end

  // State, shadow and registered output flops.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      active_q  <= 1'b0;
      update_q  <= 1'b0;
      arm_q     <= 1'b0;
      rst_q     <= 1'b0;
      pend_q    <= 1'b0;
      sh_sel_q  <= {SEL_W{1'b0}};
      sh_mode_q <= 3'd0;
      sel_q     <= {SEL_W{1'b0}};
      mode_q    <= 3'd0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      update_q  <= update_d;
      arm_q     <= arm_d;
      rst_q     <= rst_d;
      pend_q    <= pend_d;
      sh_sel_q  <= sh_sel_d;
      sh_mode_q <= sh_mode_d;
      sel_q     <= sel_d;
      mode_q    <= mode_d;
    end
  end

  assign ctrl_active_o = active_q;
  assign ctrl_update_o = update_q;
  assign ctrl_arm_o    = arm_q;
  assign ctrl_rst_o    = rst_q;
  assign cfg_sel_o     = sel_q;
  assign cfg_mode_o    = mode_q;
  assign upd_pending_o = pend_q;

endmodule
